inv_cipher: RTL and testbench

INV_CIPHER -- requirements
Module: inv_cipher

---
 rtl/inv_cipher.sv | 207 ++++++++++++++++++++
 tb/tb_inv_cipher.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_cipher.sv
// ---------------------------------------------------------------------------
// inv_cipher -- iterative AES inverse cipher (FIPS-197 InvCipher)
//
// One round per clock. A block is loaded with start, NR more edges run the
// rounds NR-1 .. 0, and the plaintext appears on Decrypted_Msg together with a
// one-cycle done pulse. All 128-bit buses use [0:127] ordering: bit 0 is the
// MSB of byte 0 and bytes fill the AES state column by column.
//
// Parameters
//   NK            key length in 32-bit words (4, 6 or 8)
//   NR            number of rounds (NK + 6)
// Ports
//   sclk          clock, rising edge
//   rst           asynchronous active-high reset
//   start         begin a decryption (ignored while busy)
//   init          ciphertext block, captured on the load edge
//   w             expanded key schedule, round key r at w[128*r +: 128]
//   Decrypted_Msg plaintext, held until the next completed decryption
//   busy          high while a decryption is running
//   done          one-cycle pulse when Decrypted_Msg is updated
//
// Build option
//   INV_CIPHER_KEY_LATCH_EN  when defined, the whole key schedule is copied
//                            on the load edge so w may change while busy;
//                            otherwise w is read directly and must be held
//                            stable until done.
// ---------------------------------------------------------------------------
module inv_cipher #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [0:127]           init,
    input  logic [0:128*(NR+1)-1]  w,
    output logic [0:127]           Decrypted_Msg,
    output logic                   busy,
    output logic                   done
);

    // NR = NK + 6, so NK + 7 round keys need indexing by the round counter.
    localparam int CW = $clog2(NK + 7);
    localparam int KW = 128 * (NR + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One InvMixColumns column: matrix {0e,0b,0d,09} rotated per row.
    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t          stateQ;
    logic [CW-1:0]   roundQ;
    logic [0:127]    stQ;
    logic [0:127]    stD;
    logic [0:127]    msgQ;
    logic            busyQ;
    logic            doneQ;
    logic [0:KW-1]   keySrc;
    logic [0:127]    roundKeys [NR+1];
    logic [0:127]    keyCur;
    logic [0:127]    keyNr;
    logic [7:0]      srB [16];
    logic [7:0]      akB [16];

`ifdef INV_CIPHER_KEY_LATCH_EN
    logic [0:KW-1]   keyQ;

    // Snapshot of the key schedule taken on the load edge.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            keyQ <= '0;
        end else if (stateQ == S_IDLE && start) begin
            keyQ <= w;
        end
    end

    assign keySrc = keyQ;
`else
    assign keySrc = w;
`endif

    // The load edge needs round key NR before any snapshot exists, so it
    // always comes straight from w.
    assign keyNr = w[128*NR +: 128];

    always_comb begin
        for (int i = 0; i <= NR; i++) begin
            roundKeys[i] = keySrc[128*i +: 128];
        end
        keyCur = roundKeys[roundQ];
    end

    // One inverse round on the current state. Round 0 skips InvMixColumns.
    always_comb begin
        stD = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                srB[4*c+r] = stQ[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        for (int k = 0; k < 16; k++) begin
            akB[k] = INV_SBOX[srB[k]] ^ keyCur[8*k +: 8];
        end
        for (int c = 0; c < 4; c++) begin
            if (roundQ == '0) begin
                stD[32*c +: 32] = {akB[4*c], akB[4*c+1], akB[4*c+2], akB[4*c+3]};
            end else begin
                stD[32*c +: 32] = invMixCol({akB[4*c], akB[4*c+1], akB[4*c+2], akB[4*c+3]});
            end
        end
    end

    // Control: load on start when idle, then count rounds down to 0 and
    // publish the result with a single-cycle done.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            stateQ <= S_IDLE;
            roundQ <= '0;
            stQ    <= '0;
            msgQ   <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            case (stateQ)
                S_IDLE: begin
                    doneQ <= 1'b0;
                    if (start) begin
                        stQ    <= init ^ keyNr;
                        roundQ <= CW'(NR - 1);
                        busyQ  <= 1'b1;
                        stateQ <= S_RUN;
                    end
                end
                S_RUN: begin
                    stQ <= stD;
                    if (roundQ == '0) begin
                        msgQ   <= stD;
                        doneQ  <= 1'b1;
                        busyQ  <= 1'b0;
                        stateQ <= S_IDLE;
                    end else begin
                        roundQ <= roundQ - CW'(1);
                        doneQ  <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= S_IDLE;
                    busyQ  <= 1'b0;
                    doneQ  <= 1'b0;
                end
            endcase
        end
    end

    assign Decrypted_Msg = msgQ;
    assign busy          = busyQ;
    assign done          = doneQ;

endmodule

// File: tb/tb_inv_cipher.sv
// ---------------------------------------------------------------------------
// tb_inv_cipher -- self-checking bench for inv_cipher
//
// Three instances (AES-128/192/256) share clock, reset, start and init.
// Expected plaintexts come from known-answer vectors or from a forward AES
// model in this file: a random plaintext is encrypted here and the DUT must
// recover it. The S-box is derived from GF(2^8) inversion plus the affine map.
// ---------------------------------------------------------------------------
module tb_inv_cipher;

    logic           sclk = 1'b0;
    logic           rst;
    logic           start;
    logic [0:127]   init;
    logic [0:1407]  w4;
    logic [0:1663]  w6;
    logic [0:1919]  w8;
    logic [0:127]   msg4, msg6, msg8;
    logic           busy4, busy6, busy8;
    logic           done4, done6, done8;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] sbox [256];

    inv_cipher #(.NK(4), .NR(10)) dut4 (
        .sclk(sclk), .rst(rst), .start(start), .init(init), .w(w4),
        .Decrypted_Msg(msg4), .busy(busy4), .done(done4)
    );
    inv_cipher #(.NK(6), .NR(12)) dut6 (
        .sclk(sclk), .rst(rst), .start(start), .init(init), .w(w6),
        .Decrypted_Msg(msg6), .busy(busy6), .done(done6)
    );
    inv_cipher #(.NK(8), .NR(14)) dut8 (
        .sclk(sclk), .rst(rst), .start(start), .init(init), .w(w8),
        .Decrypted_Msg(msg8), .busy(busy8), .done(done8)
    );

    always #5 sclk = ~sclk;

    // Generic GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse followed by the affine transform.
    task automatic buildSbox();
        logic [7:0] inv;
        logic [7:0] o;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox[x] = o;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // FIPS-197 KeyExpansion; round key r lands at [128*r +: 128].
    function automatic logic [0:1919] expandKey(input logic [0:255] key, input int nk);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1919] out = '0;
        int            total = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) wd[i] = key[32*i +: 32];
        for (int i = nk; i < total; i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) out[32*i +: 32] = wd[i];
        return out;
    endfunction

    // Forward FIPS-197 Cipher, used to manufacture ciphertexts.
    function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1919] ek, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [0:127] res;
        for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ ek[8*k +: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = s[r+4*((c+r)%4)];
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end
            end else begin
                for (int k = 0; k < 16; k++) s[k] = t[k];
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ ek[128*rd + 8*k +: 8];
        end
        for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
        return res;
    endfunction

    function automatic logic getDone(input int nk);
        case (nk)
            4:       return done4;
            6:       return done6;
            default: return done8;
        endcase
    endfunction

    function automatic logic getBusy(input int nk);
        case (nk)
            4:       return busy4;
            6:       return busy6;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [0:127] getMsg(input int nk);
        case (nk)
            4:       return msg4;
            6:       return msg6;
            default: return msg8;
        endcase
    endfunction

    function automatic logic [0:127] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic setKey(input int nk, input logic [0:255] key, output logic [0:1919] ek);
        ek = expandKey(key, nk);
        case (nk)
            4:       w4 = ek[0:1407];
            6:       w6 = ek[0:1663];
            default: w8 = ek[0:1919];
        endcase
    endtask

    // Wait for the instance to go idle, pulse start for one cycle, scramble
    // init after the load edge, and count edges (load edge = 1) until done.
    task automatic runOp(input int nk, input logic [0:127] ct, output logic [0:127] res,
                         output int edges, output logic sawDone, output logic busyAtLoad);
        int guard = 0;
        while (getBusy(nk) && guard < 40) begin
            @(negedge sclk);
            guard++;
        end
        @(negedge sclk);
        init  = ct;
        start = 1'b1;
        @(negedge sclk);
        start      = 1'b0;
        init       = randBlock();
        busyAtLoad = getBusy(nk);
        edges      = 1;
        while (!getDone(nk) && edges < 64) begin
            @(negedge sclk);
            edges++;
        end
        sawDone = getDone(nk);
        res     = getMsg(nk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        init  = '0;
        w4    = '0;
        w6    = '0;
        w8    = '0;
        repeat (3) @(negedge sclk);
        nChecks++; if (busy4 !== 1'b0) begin nFails++; $display("FAIL reset_busy4 got %b want 0", busy4); end
        nChecks++; if (done4 !== 1'b0) begin nFails++; $display("FAIL reset_done4 got %b want 0", done4); end
        nChecks++; if (msg4 !== 128'h0) begin nFails++; $display("FAIL reset_msg4 got %h want 0", msg4); end
        nChecks++; if (busy6 !== 1'b0 || done6 !== 1'b0) begin nFails++; $display("FAIL reset_ctl6 got %b%b want 00", busy6, done6); end
        nChecks++; if (msg8 !== 128'h0) begin nFails++; $display("FAIL reset_msg8 got %h want 0", msg8); end
        rst = 1'b0;
        @(negedge sclk);
    endtask

    task automatic test_fips_vector();
        logic [0:1919] ek;
        logic [0:127]  res;
        int            edges;
        logic          saw, bl;
        setKey(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, ek);
        runOp(4, 128'h3925841d02dc09fbdc118597196a0b32, res, edges, saw, bl);
        nChecks++; if (bl !== 1'b1) begin nFails++; $display("FAIL fips_busy got %b want 1", bl); end
        nChecks++; if (saw !== 1'b1) begin nFails++; $display("FAIL fips_done got %b want 1", saw); end
        nChecks++; if (res !== 128'h3243f6a8885a308d313198a2e0370734) begin nFails++; $display("FAIL fips_msg got %h want 3243f6a8885a308d313198a2e0370734", res); end
        nChecks++; if (edges != 11) begin nFails++; $display("FAIL fips_latency got %0d want 11", edges); end
        @(negedge sclk);
        nChecks++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin nFails++; $display("FAIL fips_pulse got done=%b busy=%b want 0 0", done4, busy4); end
    endtask

    task automatic test_nk_vectors();
        logic [0:1919] ek;
        logic [0:127]  res;
        int            edges;
        logic          saw, bl;
        setKey(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, ek);
        runOp(4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, res, edges, saw, bl);
        nChecks++; if (res !== 128'h00112233445566778899aabbccddeeff) begin nFails++; $display("FAIL nk4_msg got %h want 00112233445566778899aabbccddeeff", res); end
        setKey(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, ek);
        runOp(6, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, res, edges, saw, bl);
        nChecks++; if (res !== 128'h00112233445566778899aabbccddeeff) begin nFails++; $display("FAIL nk6_msg got %h want 00112233445566778899aabbccddeeff", res); end
        nChecks++; if (edges != 13) begin nFails++; $display("FAIL nk6_latency got %0d want 13", edges); end
        setKey(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, ek);
        runOp(8, 128'h8ea2b7ca516745bfeafc49904b496089, res, edges, saw, bl);
        nChecks++; if (res !== 128'h00112233445566778899aabbccddeeff) begin nFails++; $display("FAIL nk8_msg got %h want 00112233445566778899aabbccddeeff", res); end
        nChecks++; if (edges != 15) begin nFails++; $display("FAIL nk8_latency got %0d want 15", edges); end
    endtask

    task automatic test_random();
        int            nkTab [3] = '{4, 6, 8};
        int            nk;
        logic [0:255]  key;
        logic [0:1919] ek;
        logic [0:127]  pt, res;
        int            edges;
        logic          saw, bl;
        for (int i = 0; i < 9; i++) begin
            nk  = nkTab[i % 3];
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = randBlock();
            setKey(nk, key, ek);
            runOp(nk, encrypt(pt, ek, nk + 6), res, edges, saw, bl);
            nChecks++; if (res !== pt || edges != nk + 7) begin nFails++; $display("FAIL random_nk%0d got %h/%0d want %h/%0d", nk, res, edges, pt, nk + 7); end
        end
    endtask

    // The previous result must stay on the output while the next block runs.
    task automatic test_hold();
        logic [0:1919] ek;
        logic [0:127]  ptA, ptB, res;
        int            edges;
        logic          saw, bl;
        ptA = randBlock();
        ptB = randBlock();
        setKey(4, {$urandom, $urandom, $urandom, $urandom, 128'h0}, ek);
        runOp(4, encrypt(ptA, ek, 10), res, edges, saw, bl);
        @(negedge sclk);
        init  = encrypt(ptB, ek, 10);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (msg4 !== ptA) begin nFails++; $display("FAIL hold_msg cycle %0d got %h want %h", k, msg4, ptA); end
            repeat (2) @(negedge sclk);
        end
        edges = 0;
        while (!done4 && edges < 40) begin @(negedge sclk); edges++; end
        nChecks++; if (msg4 !== ptB) begin nFails++; $display("FAIL hold_next got %h want %h", msg4, ptB); end
    endtask

    // Extra start and init changes mid-run must not disturb the operation.
    task automatic test_ignore_start();
        logic [0:1919] ek;
        logic [0:127]  res;
        int            pulses, edges, doneAt;
        logic          saw, bl;
        setKey(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, ek);
        while (busy4) @(negedge sclk);
        @(negedge sclk);
        init  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        start = 1'b1;
        @(negedge sclk);
        start  = 1'b0;
        pulses = 0;
        doneAt = 0;
        res    = '0;
        for (int e = 1; e <= 30; e++) begin
            init  = randBlock();
            start = (e == 3 || e == 6);
            if (done4) begin
                pulses++;
                if (doneAt == 0) begin doneAt = e; res = msg4; end
            end
            @(negedge sclk);
        end
        start = 1'b0;
        nChecks++; if (res !== 128'h00112233445566778899aabbccddeeff) begin nFails++; $display("FAIL ignore_msg got %h want 00112233445566778899aabbccddeeff", res); end
        nChecks++; if (pulses != 1) begin nFails++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        nChecks++; if (doneAt != 11) begin nFails++; $display("FAIL ignore_latency got %0d want 11", doneAt); end
        runOp(4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, res, edges, saw, bl);
        nChecks++; if (bl !== 1'b1 || res !== 128'h00112233445566778899aabbccddeeff) begin nFails++; $display("FAIL ignore_restart got busy=%b %h want busy=1 00112233445566778899aabbccddeeff", bl, res); end
    endtask

    // Start asserted in the done cycle launches the next block immediately.
    task automatic test_back_to_back();
        logic [0:1919] ek;
        logic [0:127]  pt1, pt2, res1;
        int            edges;
        pt1 = randBlock();
        pt2 = randBlock();
        setKey(4, {$urandom, $urandom, $urandom, $urandom, 128'h0}, ek);
        while (busy4) @(negedge sclk);
        @(negedge sclk);
        init  = encrypt(pt1, ek, 10);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        edges = 1;
        while (!done4 && edges < 40) begin @(negedge sclk); edges++; end
        res1  = msg4;
        init  = encrypt(pt2, ek, 10);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        edges = 1;
        while (!done4 && edges < 40) begin @(negedge sclk); edges++; end
        nChecks++; if (res1 !== pt1) begin nFails++; $display("FAIL b2b_first got %h want %h", res1, pt1); end
        nChecks++; if (msg4 !== pt2 || edges != 11) begin nFails++; $display("FAIL b2b_second got %h/%0d want %h/11", msg4, edges, pt2); end
    endtask

    task automatic test_reset_mid();
        logic [0:1919] ek;
        logic [0:127]  res;
        int            pulses, edges;
        logic          saw, bl;
        setKey(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, ek);
        while (busy4) @(negedge sclk);
        @(negedge sclk);
        init  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        repeat (5) @(negedge sclk);
        rst = 1'b1;
        #1;
        nChecks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin nFails++; $display("FAIL rstmid_ctl got busy=%b done=%b want 0 0", busy4, done4); end
        nChecks++; if (msg4 !== 128'h0) begin nFails++; $display("FAIL rstmid_msg got %h want 0", msg4); end
        @(negedge sclk);
        rst    = 1'b0;
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            @(negedge sclk);
            if (done4) pulses++;
        end
        nChecks++; if (pulses != 0) begin nFails++; $display("FAIL rstmid_pulses got %0d want 0", pulses); end
        runOp(4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, res, edges, saw, bl);
        nChecks++; if (res !== 128'h00112233445566778899aabbccddeeff || edges != 11) begin nFails++; $display("FAIL rstmid_rerun got %h/%0d want 00112233445566778899aabbccddeeff/11", res, edges); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        buildSbox();
        test_reset();
        test_fips_vector();
        test_nk_vectors();
        test_random();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
